mul_seq_unit: RTL and testbench
===============================

Name: mul_seq_unit

Overview:
- Multi-cycle RV32M multiply unit in the execute stage of the in-order single-issue core.
- Accepts operands from issue over a valid/ready handshake.
- Computes the 64-bit product as four 16x16 unsigned partial products on the vedic16bmul array, accumulating one per cycle.
- Returns the selected 32-bit result to writeback over a valid/ready handshake.

Parameters:
- XLEN, 32, operand/result width; must be even. HALF = XLEN/2 is derived and feeds the partial-product array.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  issue presents an operation.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- rs1  input  XLEN  multiplicand.
- rs2  input  XLEN  multiplier.
- rd_tag  input  5  destination register tag, carried through.
- flush  input  1  synchronous pipeline kill.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts the result.
- result  output  XLEN  selected product half.
- out_tag  output  5  rd_tag of the completed operation.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, acc=0, neg=0, op_q=0, out_tag=0, out_valid=0, result=0, busy=0, in_ready=0 while rst_n low. All outputs zero immediately, even mid-operation.
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC on in_valid & in_ready & !flush, at the accept edge N. At N the unit latches:
  - magnitudes |rs1|, |rs2|. rs1 is signed for MULH and MULHSU. rs2 is signed for MULH only. MUL operands are treated as unsigned.
  - neg = sign(rs1 as interpreted) XOR sign(rs2 as interpreted).
  - op_q, out_tag, cnt=0, acc=0.
- CALC: one partial product per edge, added to the 64-bit acc:
  - cnt0: lo*lo.
  - cnt1: lo*hi << 16.
  - cnt2: hi*lo << 16.
  - cnt3: hi*hi << 32.
- cnt3 edge (N+4): CALC -> DONE.
- Latency: out_valid high from edge N+4, i.e. 4 cycles after acceptance.
- DONE:
  - final = neg ? -acc : acc (64-bit two's complement; zero stays zero).
  - result = final[31:0] for MUL, final[63:32] otherwise.
  - result is driven from registers through sign-fix/select logic only.
- DONE -> IDLE on out_valid & out_ready. in_ready rises the following cycle; there is no same-cycle re-accept. Maximum throughput is one operation per 6 cycles.
- Back-pressure: while out_ready=0 in DONE, result and out_tag hold stable.
- Flush, any state -> IDLE at the next edge; out_valid=0 and busy=0 after that edge. flush wins over simultaneous in_valid (no accept) and over a simultaneous out_ready (the result is discarded).
- Width rules:
  - Partial products are HALF x HALF -> XLEN, zero-extended to 2*XLEN before the shift.
  - acc is 2*XLEN wide and cannot overflow for magnitudes up to 2^31.
- MULH of 0x80000000 * 0x80000000 is exact (product +2^62).

Decomposition:
- mul_pkg:
  - XLEN localparam;
  - mul_op_e enum (MUL, MULH, MULHSU, MULHU);
  - mul_state_e enum (IDLE, CALC, DONE);
  - a helper function returning the operand-signedness pair for an op.
- Sub-module vedic16bmul: combinational HALF x HALF -> XLEN unsigned multiplier, built hierarchically from the existing vedic2bmul cell. It is instantiated once and time-multiplexed by cnt.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, tag=5, out_ready=1 -> out_valid exactly 4 cycles after accept, result=0xFFFFFFEB, out_tag=5, then in_ready=1 next cycle.
- Corner products:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MUL same operands -> 0x00000001.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF. MULHSU rs1=2, rs2=0x80000000 -> 0x00000001.
- Back-pressure: MULHU 0x10000*0x10000 with out_ready=0 for 3 cycles -> result=0x00000001 and out_tag stable, in_ready=0, busy=1. After the handshake, in_ready=1 next cycle.
- flush asserted at cnt=2 -> IDLE next edge, out_valid never asserts. A following MUL 3*4 -> 12. flush together with in_valid in IDLE -> no accept.
- rst_n driven low mid-CALC, between edges -> out_valid, busy, result and out_tag read 0 before the next edge. After release, MUL 0*0xFFFFFFFF -> 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the RV32M sequential multiply unit.
package mul_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Returns {rs1_signed, rs2_signed} for the given operation.
  function automatic logic [1:0] op_signedness(input mul_op_e o);
    logic [1:0] s;
    case (o)
      MULH:    s = 2'b11;
      MULHSU:  s = 2'b10;
      default: s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vedic16bmul.sv
// 16x16 -> 32 unsigned Vedic multiplier built from four 8x8 blocks.
module vedic16bmul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [15:0] q_ll;
  logic [15:0] q_hl;
  logic [15:0] q_lh;
  logic [15:0] q_hh;

  vedic8bmul u_ll (.a(a[7:0]),  .b(b[7:0]),  .p(q_ll));
  vedic8bmul u_hl (.a(a[15:8]), .b(b[7:0]),  .p(q_hl));
  vedic8bmul u_lh (.a(a[7:0]),  .b(b[15:8]), .p(q_lh));
  vedic8bmul u_hh (.a(a[15:8]), .b(b[15:8]), .p(q_hh));

  assign p = {16'b0, q_ll} + {8'b0, q_hl, 8'b0} + {8'b0, q_lh, 8'b0} + {q_hh, 16'b0};

endmodule

// File: rtl/vedic2bmul.sv
// 2x2 unsigned Vedic multiplier cell (urdhva-tiryagbhyam, gate level).
module vedic2bmul (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic t_lh;
  logic t_hl;
  logic t_hh;
  logic c1;

  assign t_lh = a[0] & b[1];
  assign t_hl = a[1] & b[0];
  assign t_hh = a[1] & b[1];
  assign c1   = t_lh & t_hl;

  assign p[0] = a[0] & b[0];
  assign p[1] = t_lh ^ t_hl;
  assign p[2] = t_hh ^ c1;
  assign p[3] = t_hh & c1;

endmodule

// File: rtl/vedic4bmul.sv
// 4x4 unsigned Vedic multiplier built from four 2x2 cells.
module vedic4bmul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0] q_ll;
  logic [3:0] q_hl;
  logic [3:0] q_lh;
  logic [3:0] q_hh;

  vedic2bmul u_ll (.a(a[1:0]), .b(b[1:0]), .p(q_ll));
  vedic2bmul u_hl (.a(a[3:2]), .b(b[1:0]), .p(q_hl));
  vedic2bmul u_lh (.a(a[1:0]), .b(b[3:2]), .p(q_lh));
  vedic2bmul u_hh (.a(a[3:2]), .b(b[3:2]), .p(q_hh));

  assign p = {4'b0, q_ll} + {2'b0, q_hl, 2'b0} + {2'b0, q_lh, 2'b0} + {q_hh, 4'b0};

endmodule

// File: rtl/vedic8bmul.sv
// 8x8 unsigned Vedic multiplier built from four 4x4 blocks.
module vedic8bmul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [7:0] q_ll;
  logic [7:0] q_hl;
  logic [7:0] q_lh;
  logic [7:0] q_hh;

  vedic4bmul u_ll (.a(a[3:0]), .b(b[3:0]), .p(q_ll));
  vedic4bmul u_hl (.a(a[7:4]), .b(b[3:0]), .p(q_hl));
  vedic4bmul u_lh (.a(a[3:0]), .b(b[7:4]), .p(q_lh));
  vedic4bmul u_hh (.a(a[7:4]), .b(b[7:4]), .p(q_hh));

  assign p = {8'b0, q_ll} + {4'b0, q_hl, 4'b0} + {4'b0, q_lh, 4'b0} + {q_hh, 8'b0};

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential RV32M multiplier: sign-magnitude operands, four half-width
// partial products accumulated over four cycles, sign fixed at the output.
module mul_seq_unit #(
  parameter int XLEN = mul_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_tag,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_tag,
  output logic            busy
);

  import mul_pkg::*;

  localparam int HALF = XLEN / 2;
  localparam int PW   = 2 * XLEN;

  // Magnitude of an operand that may be interpreted as signed.
  function automatic logic [XLEN-1:0] abs_op(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  // Re-applies the product sign; a zero magnitude stays zero.
  function automatic logic [PW-1:0] sign_fix(input logic [PW-1:0] p, input logic ng);
    return ng ? (~p + 1'b1) : p;
  endfunction

  // MUL returns the low word, every high variant the upper word.
  function automatic logic [XLEN-1:0] sel_half(input mul_op_e o, input logic [PW-1:0] f);
    return (o == MUL) ? f[XLEN-1:0] : f[PW-1:XLEN];
  endfunction

  mul_state_e      state;
  logic [1:0]      cnt;
  logic [PW-1:0]   acc;
  logic            neg;
  mul_op_e         op_q;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;

  mul_op_e         op_in;
  logic [1:0]      sgn_in;
  logic            take;
  logic [HALF-1:0] pa;
  logic [HALF-1:0] pb;
  logic [XLEN-1:0] pp;
  logic [PW-1:0]   pp_sh;

  assign op_in  = mul_op_e'(op);
  assign sgn_in = op_signedness(op_in);
  assign take   = (state == IDLE) && in_valid && in_ready && !flush;

  // Select which operand halves feed the shared multiplier this cycle.
  always_comb begin
    pa = mag1[HALF-1:0];
    pb = mag2[HALF-1:0];
    case (cnt)
      2'd1: pb = mag2[XLEN-1:HALF];
      2'd2: pa = mag1[XLEN-1:HALF];
      2'd3: begin
        pa = mag1[XLEN-1:HALF];
        pb = mag2[XLEN-1:HALF];
      end
      default: ;
    endcase
  end

  vedic16bmul u_pp (
    .a (pa),
    .b (pb),
    .p (pp)
  );

  // Align the zero-extended partial product to its weight.
  always_comb begin
    pp_sh = PW'(pp);
    case (cnt)
      2'd1, 2'd2: pp_sh = PW'(pp) << HALF;
      2'd3:       pp_sh = PW'(pp) << XLEN;
      default:    ;
    endcase
  end

  // Operand magnitudes are pure data and are only loaded on accept.
  always_ff @(posedge clk) begin
    if (take) begin
      mag1 <= abs_op(rs1, sgn_in[1]);
      mag2 <= abs_op(rs2, sgn_in[0]);
    end
  end

  // Control FSM with registered handshake outputs and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      acc       <= '0;
      neg       <= 1'b0;
      op_q      <= MUL;
      out_tag   <= 5'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            cnt      <= 2'd0;
            acc      <= '0;
            neg      <= (sgn_in[1] & rs1[XLEN-1]) ^ (sgn_in[0] & rs2[XLEN-1]);
            op_q     <= op_in;
            out_tag  <= rd_tag;
          end
        end
        CALC: begin
          acc <= acc + pp_sh;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result = sel_half(op_q, sign_fix(acc, neg));

endmodule

// File: tb/tb_mul_seq_unit.sv
// Testbench for mul_seq_unit: directed corners plus randomized operations
// checked against an arithmetic reference product.
module tb_mul_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_tag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_seq_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd_tag    (rd_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  // Reference: exact product of the operands as the op interprets them.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] x;
    logic signed [32:0] y;
    logic signed [65:0] p;
    x = (o == 2'd1 || o == 2'd2) ? $signed({a[31], a}) : $signed({1'b0, a});
    y = (o == 2'd1) ? $signed({b[31], b}) : $signed({1'b0, b});
    p = x * y;
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      4: v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] t, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    if (ok) begin
      op = o; rs1 = a; rs2 = b; rd_tag = t; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      rs1 = $urandom; rs2 = $urandom; rd_tag = 5'($urandom); op = 2'($urandom);
    end
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, output logic [31:0] r, output logic [4:0] tg,
                        output int lat, output bit ok, output int waited);
    bit ok_a;
    bit ok_v;
    accept_op(o, a, b, t, ok_a, waited);
    lat = -1;
    ok_v = 1'b0;
    if (ok_a) wait_valid(lat, ok_v);
    ok = ok_a && ok_v;
    r  = result;
    tg = out_tag;
    if (ok) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op = 2'd0; rs1 = '0; rs2 = '0; rd_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    #2;
    total++;
    if ({in_ready, out_valid, busy, out_tag, result} !== 40'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b tag=%h res=%h required all zero",
               in_ready, out_valid, busy, out_tag, result);
    end
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b busy=%b vld=%b required 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    int waited;
    out_ready = 1'b1;
    accept_op(2'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, ok, waited);
    wait_valid(lat, ok);
    total++;
    if (!ok || lat != 4) begin
      bad++;
      $display("FAIL basic_latency: got %0d required 4", lat);
    end
    total++;
    if (result !== 32'hFFFF_FFEB || out_tag !== 5'd5) begin
      bad++;
      $display("FAIL basic_result: got %h tag %0d required ffffffeb tag 5", result, out_tag);
    end
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_done_ctrl: got rdy=%b busy=%b required 0 1", in_ready, busy);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_after_hs: got vld=%b rdy=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_corners();
    logic [1:0]  ops  [6] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1};
    logic [31:0] as   [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB};
    logic [31:0] bs   [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    logic [31:0] exps [6] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    logic [31:0] r;
    logic [4:0]  tg;
    int lat;
    int waited;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 10), r, tg, lat, ok, waited);
      total++;
      if (!ok || lat != 4 || r !== exps[i] || tg !== 5'(i + 10)) begin
        bad++;
        $display("FAIL corner_%0d: got res=%h tag=%0d lat=%0d required res=%h tag=%0d lat=4",
                 i, r, tg, lat, exps[i], i + 10);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int waited;
    out_ready = 1'b0;
    accept_op(2'd3, 32'h0001_0000, 32'h0001_0000, 5'd9, ok, waited);
    wait_valid(lat, ok);
    total++;
    if (!ok || lat != 4) begin
      bad++;
      $display("FAIL bp_latency: got %0d required 4", lat);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || result !== 32'h1 || out_tag !== 5'd9 || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold_%0d: got vld=%b res=%h tag=%0d rdy=%b busy=%b required 1 00000001 9 0 1",
                 i, out_valid, result, out_tag, in_ready, busy);
      end
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    bit ok;
    bit seen;
    int lat;
    int waited;
    logic [31:0] r;
    logic [4:0]  tg;
    out_ready = 1'b1;
    accept_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, ok, waited);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_calc: got vld=%b busy=%b required 0 0", out_valid, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL flush_no_valid: got out_valid seen=1 required 0");
    end
    run_op(2'd0, 32'd3, 32'd4, 5'd21, r, tg, lat, ok, waited);
    total++;
    if (!ok || lat != 4 || r !== 32'd12 || tg !== 5'd21) begin
      bad++;
      $display("FAIL flush_next_op: got res=%h tag=%0d lat=%0d required 0000000c 21 4", r, tg, lat);
    end
    op = 2'd0; rs1 = 32'd5; rs2 = 32'd6; rd_tag = 5'd2;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid || busy) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL flush_blocks_accept: got busy/valid seen=1 required 0");
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int lat;
    int waited;
    logic [31:0] r;
    logic [4:0]  tg;
    out_ready = 1'b1;
    accept_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, ok, waited);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, busy, out_tag, result} !== 40'd0) begin
      bad++;
      $display("FAIL async_reset: got rdy=%b vld=%b busy=%b tag=%h res=%h required all zero",
               in_ready, out_valid, busy, out_tag, result);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_release: got rdy=%b vld=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    end
    run_op(2'd0, 32'd0, 32'hFFFF_FFFF, 5'd30, r, tg, lat, ok, waited);
    total++;
    if (!ok || lat != 4 || r !== 32'd0 || tg !== 5'd30) begin
      bad++;
      $display("FAIL async_next_op: got res=%h tag=%0d lat=%0d required 00000000 30 4", r, tg, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  t;
    logic [31:0] r;
    logic [4:0]  tg;
    logic [31:0] exp_r;
    int lat;
    int waited;
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      t = 5'($urandom);
      exp_r = ref_result(o, a, b);
      run_op(o, a, b, t, r, tg, lat, ok, waited);
      total++;
      if (!ok || r !== exp_r || tg !== t) begin
        bad++;
        $display("FAIL rand_%0d op=%0d a=%h b=%h: got res=%h tag=%0d required res=%h tag=%0d",
                 i, o, a, b, r, tg, exp_r, t);
      end
      total++;
      if (lat != 4 || (i > 0 && waited != 0)) begin
        bad++;
        $display("FAIL rand_timing_%0d: got lat=%0d wait=%0d required 4 0", i, lat, waited);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
